// File: rtl/controller_pkg.sv
// KGP miniRISC decoder constants: opcodes, func codes,
// ALU/next-PC/write-back encodings and IR field positions.
package controller_pkg;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RS_HI   = 11;
  localparam int RS_LO   = 7;
  localparam int RT_HI   = 6;
  localparam int RT_LO   = 2;
  localparam int FUNC_HI = 1;
  localparam int FUNC_LO = 0;

  typedef enum logic [3:0] {
    OPC_ALU   = 4'b0000,
    OPC_SHR   = 4'b0001,
    OPC_ADDI  = 4'b0010,
    OPC_COMPI = 4'b0011,
    OPC_SHLLI = 4'b0100,
    OPC_SHRLI = 4'b0101,
    OPC_SHRAI = 4'b0110,
    OPC_LD    = 4'b0111,
    OPC_ST    = 4'b1000,
    OPC_BR    = 4'b1001,
    OPC_BCND  = 4'b1010,
    OPC_BMISC = 4'b1011,
    OPC_CALL  = 4'b1100,
    OPC_RSVD  = 4'b1101,
    OPC_RSV2  = 4'b1110,
    OPC_HALT  = 4'b1111
  } opc_e;

  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] F1 = 2'b01;
  localparam logic [1:0] F2 = 2'b10;
  localparam logic [1:0] F3 = 2'b11;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_XOR  = 3'b010,
    OP_SHLL = 3'b011,
    OP_SHRL = 3'b100,
    OP_SHRA = 3'b101,
    OP_PASS = 3'b110,
    OP_ADIF = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    SC_SEQ = 3'b000,
    SC_UNC = 3'b001,
    SC_Z   = 3'b010,
    SC_NZ  = 3'b011,
    SC_N   = 3'b100,
    SC_P   = 3'b101,
    SC_C   = 3'b110,
    SC_JR  = 3'b111
  } sc_e;

  typedef enum logic [1:0] {
    SB_ALU  = 2'b00,
    SB_MEM  = 2'b01,
    SB_LINK = 2'b10,
    SB_RSVD = 2'b11
  } sb_e;

  typedef struct packed {
    logic       ssw;
    logic       wr;
    logic       ss;
    logic       spc;
    logic [2:0] sc;
    logic [1:0] sb;
    logic       sa;
    logic [2:0] op;
    logic       diff;
    logic       wa;
    logic       wb;
  } dec_t;

endpackage

// File: rtl/controller_if.sv
// Instruction-in / decode-out bundle between the IR,
// the controller and the datapath.
interface controller_if;
  logic [15:0] IR;
  logic        HLT;
  logic        SSW;
  logic        WR;
  logic        SS;
  logic        SPC;
  logic [2:0]  SC;
  logic [1:0]  SB;
  logic        SA;
  logic [2:0]  OP;
  logic        DIFF;
  logic [4:0]  RTA;
  logic [4:0]  RSA;
  logic        WA;
  logic        WB;

  modport master (
    output IR, HLT,
    input  SSW, WR, SS, SPC, SC, SB, SA,
    input  OP, DIFF, RTA, RSA, WA, WB
  );

  modport slave (
    input  IR, HLT,
    output SSW, WR, SS, SPC, SC, SB, SA,
    output OP, DIFF, RTA, RSA, WA, WB
  );
endinterface

// File: rtl/controller.sv
// KGP miniRISC instruction decoder and halt sequencer.
// Zero-latency decode; the only state is the halted flop.
module controller
  import controller_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  controller_if.slave bus
);

  logic [3:0] opc;
  logic [1:0] fn;
  logic       halted;
  logic       halted_n;
  logic       gate;
  dec_t       d;

  assign opc = bus.IR[OPC_HI:OPC_LO];
  assign fn  = bus.IR[FUNC_HI:FUNC_LO];

  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= halted_n;
  end

  always_comb begin
    halted_n = halted;
    if (opc == OPC_HALT) halted_n = 1'b1;
  end

  always_comb begin
    d     = '0;
    d.spc = 1'b1;
    unique case (opc)
      OPC_ALU: begin
        d.wr = 1'b1;
        unique case (fn)
          F0: d.op = OP_ADD;
          F1: d.diff = 1'b1;
          F2: d.op = OP_AND;
          F3: d.op = OP_XOR;
          default: ;
        endcase
      end
      OPC_SHR: begin
        d.wr = 1'b1;
        unique case (fn)
          F0: begin d.ssw = 1'b1; d.op = OP_SHLL; end
          F1: begin d.ssw = 1'b1; d.op = OP_SHRL; end
          F2: begin d.ssw = 1'b1; d.op = OP_SHRA; end
          F3: d.op = OP_ADIF;
          default: ;
        endcase
      end
      OPC_ADDI: begin
        d.wr = 1'b1;
        d.ss = 1'b1;
      end
      OPC_COMPI: begin
        d.wr   = 1'b1;
        d.ss   = 1'b1;
        d.op   = OP_PASS;
        d.diff = 1'b1;
      end
      OPC_SHLLI: begin
        d.wr = 1'b1; d.ss = 1'b1; d.op = OP_SHLL;
      end
      OPC_SHRLI: begin
        d.wr = 1'b1; d.ss = 1'b1; d.op = OP_SHRL;
      end
      OPC_SHRAI: begin
        d.wr = 1'b1; d.ss = 1'b1; d.op = OP_SHRA;
      end
      OPC_LD: begin
        d.wr = 1'b1;
        d.ss = 1'b1;
        d.wb = 1'b1;
        d.sb = SB_MEM;
      end
      OPC_ST: begin
        d.ss = 1'b1;
        d.wa = 1'b1;
      end
      OPC_BR: begin
        d.sa = 1'b1; d.ss = 1'b1; d.sc = SC_UNC;
      end
      OPC_BCND: begin
        d.sa = 1'b1;
        d.ss = 1'b1;
        unique case (fn)
          F0: d.sc = SC_Z;
          F1: d.sc = SC_NZ;
          F2: d.sc = SC_N;
          F3: d.sc = SC_P;
          default: ;
        endcase
      end
      OPC_BMISC: begin
        unique case (fn)
          F0: begin d.sa = 1'b1; d.ss = 1'b1; d.sc = SC_C; end
          // BNC: branch target computed but never taken
          F1: begin d.sa = 1'b1; d.ss = 1'b1; d.sc = SC_SEQ; end
          F2: d.sc = SC_JR;
          F3: ;
          default: ;
        endcase
      end
      OPC_CALL: begin
        d.sa = 1'b1;
        d.ss = 1'b1;
        d.sc = SC_UNC;
        d.wr = 1'b1;
        d.sb = SB_LINK;
      end
      OPC_HALT: d.spc = 1'b0;
      default: ;
    endcase
  end

  assign gate = halted | bus.HLT | rst;

  always_comb begin
    bus.SSW  = d.ssw;
    bus.SS   = d.ss;
    bus.SC   = d.sc;
    bus.SB   = d.sb;
    bus.SA   = d.sa;
    bus.OP   = d.op;
    bus.DIFF = d.diff;
    bus.SPC  = d.spc & ~gate;
    bus.WR   = d.wr  & ~gate;
    bus.WA   = d.wa  & ~gate;
    bus.WB   = d.wb  & ~gate;
    bus.RSA  = bus.IR[RS_HI:RS_LO];
    bus.RTA  = bus.IR[RT_HI:RT_LO];
  end

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for the miniRISC controller:
// decode fields, halt latch, HLT gating and reset.
module tb_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n = 0;
  int   errs = 0;

  controller_if bus();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [15:0] ir);
    @(negedge clk);
    bus.IR = ir;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.HLT = 1'b0;
    apply(16'h0194);
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL rst_wr got %b exp 0", bus.WR); end
    n++; if (bus.SPC !== 1'b0) begin errs++; $display("FAIL rst_spc got %b exp 0", bus.SPC); end
    n++; if (bus.RSA !== 5'd3) begin errs++; $display("FAIL rst_rsa got %0d exp 3", bus.RSA); end
    n++; if (bus.RTA !== 5'd5) begin errs++; $display("FAIL rst_rta got %0d exp 5", bus.RTA); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL add_wr got %b exp 1", bus.WR); end
    n++; if (bus.OP !== 3'b000) begin errs++; $display("FAIL add_op got %b exp 000", bus.OP); end
    n++; if (bus.DIFF !== 1'b0) begin errs++; $display("FAIL add_diff got %b exp 0", bus.DIFF); end
    n++; if (bus.SS !== 1'b0) begin errs++; $display("FAIL add_ss got %b exp 0", bus.SS); end
    n++; if (bus.SB !== 2'b00) begin errs++; $display("FAIL add_sb got %b exp 00", bus.SB); end
    n++; if (bus.SPC !== 1'b1) begin errs++; $display("FAIL add_spc got %b exp 1", bus.SPC); end
  endtask

  task automatic test_branch();
    apply(16'hA524);
    n++; if (bus.SC !== 3'b010) begin errs++; $display("FAIL bz_sc got %b exp 010", bus.SC); end
    n++; if (bus.SA !== 1'b1) begin errs++; $display("FAIL bz_sa got %b exp 1", bus.SA); end
    n++; if (bus.SS !== 1'b1) begin errs++; $display("FAIL bz_ss got %b exp 1", bus.SS); end
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL bz_wr got %b exp 0", bus.WR); end
    n++; if (bus.WA !== 1'b0) begin errs++; $display("FAIL bz_wa got %b exp 0", bus.WA); end
    n++; if (bus.RSA !== 5'd10) begin errs++; $display("FAIL bz_rsa got %0d exp 10", bus.RSA); end
    n++; if (bus.RTA !== 5'd9) begin errs++; $display("FAIL bz_rta got %0d exp 9", bus.RTA); end
    n++; if (bus.SPC !== 1'b1) begin errs++; $display("FAIL bz_spc got %b exp 1", bus.SPC); end
    apply(16'hA527);
    n++; if (bus.SC !== 3'b101) begin errs++; $display("FAIL bgtz_sc got %b exp 101", bus.SC); end
    apply(16'hB002);
    n++; if (bus.SC !== 3'b111) begin errs++; $display("FAIL jr_sc got %b exp 111", bus.SC); end
    n++; if (bus.SA !== 1'b0) begin errs++; $display("FAIL jr_sa got %b exp 0", bus.SA); end
    apply(16'hB001);
    n++; if (bus.SC !== 3'b000) begin errs++; $display("FAIL bnc_sc got %b exp 000", bus.SC); end
    n++; if (bus.SA !== 1'b1) begin errs++; $display("FAIL bnc_sa got %b exp 1", bus.SA); end
  endtask

  task automatic test_ldst();
    apply(16'h7088);
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL ld_wr got %b exp 1", bus.WR); end
    n++; if (bus.WB !== 1'b1) begin errs++; $display("FAIL ld_wb got %b exp 1", bus.WB); end
    n++; if (bus.SB !== 2'b01) begin errs++; $display("FAIL ld_sb got %b exp 01", bus.SB); end
    n++; if (bus.SS !== 1'b1) begin errs++; $display("FAIL ld_ss got %b exp 1", bus.SS); end
    n++; if (bus.OP !== 3'b000) begin errs++; $display("FAIL ld_op got %b exp 000", bus.OP); end
    n++; if (bus.WA !== 1'b0) begin errs++; $display("FAIL ld_wa got %b exp 0", bus.WA); end
    apply(16'h8088);
    n++; if (bus.WA !== 1'b1) begin errs++; $display("FAIL st_wa got %b exp 1", bus.WA); end
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL st_wr got %b exp 0", bus.WR); end
    n++; if (bus.WB !== 1'b0) begin errs++; $display("FAIL st_wb got %b exp 0", bus.WB); end
  endtask

  task automatic test_alu();
    apply(16'h0195);
    n++; if (bus.DIFF !== 1'b1) begin errs++; $display("FAIL sub_diff got %b exp 1", bus.DIFF); end
    n++; if (bus.OP !== 3'b000) begin errs++; $display("FAIL sub_op got %b exp 000", bus.OP); end
    apply(16'h0197);
    n++; if (bus.OP !== 3'b010) begin errs++; $display("FAIL xor_op got %b exp 010", bus.OP); end
    apply(16'h1194);
    n++; if (bus.SSW !== 1'b1) begin errs++; $display("FAIL shll_ssw got %b exp 1", bus.SSW); end
    n++; if (bus.OP !== 3'b011) begin errs++; $display("FAIL shll_op got %b exp 011", bus.OP); end
    apply(16'h1197);
    n++; if (bus.OP !== 3'b111) begin errs++; $display("FAIL adif_op got %b exp 111", bus.OP); end
    n++; if (bus.SSW !== 1'b0) begin errs++; $display("FAIL adif_ssw got %b exp 0", bus.SSW); end
    apply(16'h3000);
    n++; if ({bus.OP, bus.DIFF, bus.SS, bus.WR} !== 6'b110111)
      begin errs++; $display("FAIL compi got %b exp 110111", {bus.OP, bus.DIFF, bus.SS, bus.WR}); end
    apply(16'h6000);
    n++; if ({bus.OP, bus.SSW, bus.SS} !== 5'b10101)
      begin errs++; $display("FAIL shrai got %b exp 10101", {bus.OP, bus.SSW, bus.SS}); end
    apply(16'hC000);
    n++; if (bus.SB !== 2'b10) begin errs++; $display("FAIL call_sb got %b exp 10", bus.SB); end
    n++; if (bus.SC !== 3'b001) begin errs++; $display("FAIL call_sc got %b exp 001", bus.SC); end
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL call_wr got %b exp 1", bus.WR); end
    apply(16'hD123);
    n++; if ({bus.SPC, bus.WR, bus.SC, bus.SA, bus.SS} !== 7'b1000000)
      begin errs++; $display("FAIL rsvd_nop got %b exp 1000000", {bus.SPC, bus.WR, bus.SC, bus.SA, bus.SS}); end
  endtask

  task automatic test_halt();
    apply(16'hF000);
    n++; if (bus.SPC !== 1'b0) begin errs++; $display("FAIL halt_spc got %b exp 0", bus.SPC); end
    apply(16'h0194);
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL halted_wr got %b exp 0", bus.WR); end
    n++; if (bus.SPC !== 1'b0) begin errs++; $display("FAIL halted_spc got %b exp 0", bus.SPC); end
    n++; if (bus.RSA !== 5'd3) begin errs++; $display("FAIL halted_rsa got %0d exp 3", bus.RSA); end
    bus.HLT = 1'b1;
    apply(16'h7088);
    bus.HLT = 1'b0;
    apply(16'h7088);
    n++; if (bus.WB !== 1'b0) begin errs++; $display("FAIL halted_wb got %b exp 0", bus.WB); end
    n++; if (bus.SB !== 2'b01) begin errs++; $display("FAIL halted_sb got %b exp 01", bus.SB); end
    apply(16'h0194);
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL stay_wr got %b exp 0", bus.WR); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL unhalt_wr got %b exp 1", bus.WR); end
    n++; if (bus.SPC !== 1'b1) begin errs++; $display("FAIL unhalt_spc got %b exp 1", bus.SPC); end
  endtask

  task automatic test_rst_priority();
    @(negedge clk);
    rst = 1'b1;
    bus.IR = 16'hF000;
    @(negedge clk);
    rst = 1'b0;
    bus.IR = 16'h0194;
    #1;
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL rstpri_wr got %b exp 1", bus.WR); end
  endtask

  task automatic test_hlt();
    @(negedge clk);
    bus.HLT = 1'b1;
    bus.IR  = 16'h0194;
    #1;
    n++; if (bus.WR !== 1'b0) begin errs++; $display("FAIL hlt_wr got %b exp 0", bus.WR); end
    n++; if (bus.SPC !== 1'b0) begin errs++; $display("FAIL hlt_spc got %b exp 0", bus.SPC); end
    apply(16'h8088);
    n++; if (bus.WA !== 1'b0) begin errs++; $display("FAIL hlt_wa got %b exp 0", bus.WA); end
    apply(16'h0194);
    bus.HLT = 1'b0;
    #1;
    n++; if (bus.WR !== 1'b1) begin errs++; $display("FAIL resume_wr got %b exp 1", bus.WR); end
    n++; if (bus.SPC !== 1'b1) begin errs++; $display("FAIL resume_spc got %b exp 1", bus.SPC); end
  endtask

  initial begin
    bus.IR  = 16'h0000;
    bus.HLT = 1'b0;
    test_reset();
    test_branch();
    test_ldst();
    test_alu();
    test_halt();
    test_rst_priority();
    test_hlt();
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end

endmodule
